// File: rtl/fetch_queue.sv
// fetch_queue: decoupled fetch front end with a credit-checked FIFO, redirect flush and ECALL halt
module fetch_queue #(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
  parameter int                DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_o,
  output logic [AWIDTH-1:0]          imem_addr_o,
  input  logic [DWIDTH-1:0]          imem_data_i,
  input  logic                       redirect_i,
  input  logic [AWIDTH-1:0]          redirect_pc_i,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [AWIDTH-1:0]          deq_pc_o,
  output logic [DWIDTH-1:0]          deq_insn_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       halted_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [DWIDTH-1:0] ECALL = DWIDTH'(32'h00000073);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state_q, state_d;
  logic [AWIDTH-1:0]  pc_q, pc_d, req_pc_q;
  logic               inflight_q;
  logic [PW-1:0]      rd_q, wr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [AWIDTH-1:0]  pc_mem   [DEPTH];
  logic [DWIDTH-1:0]  insn_mem [DEPTH];
  logic               credit_ok, push, pop;

  // A request is only issued when a slot is reserved for its response
  assign credit_ok   = ({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
  assign imem_req_o  = rst & (state_q == RUN) & ~redirect_i & credit_ok;
  assign imem_addr_o = pc_q;
  assign push        = inflight_q & ~redirect_i;
  assign deq_valid_o = count_q != '0;
  assign pop         = deq_valid_o & deq_ready_i & ~redirect_i;
  assign deq_pc_o    = deq_valid_o ? pc_mem[rd_q] : '0;
  assign deq_insn_o  = deq_valid_o ? insn_mem[rd_q] : '0;
  assign count_o     = count_q;
  assign halted_o    = state_q == HALTED;

  always_comb begin
    pc_d    = redirect_i ? (redirect_pc_i & ~AWIDTH'(3)) : imem_req_o ? pc_q + AWIDTH'(4) : pc_q;
    count_d = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
    state_d = redirect_i ? RUN : (pop && deq_insn_o == ECALL) ? HALTED : state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= BASEADDR;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      state_q    <= RUN;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      state_q    <= state_d;
      inflight_q <= imem_req_o;
      if (imem_req_o) req_pc_q <= pc_q;
      rd_q       <= redirect_i ? '0 : pop ? rd_q + PW'(1) : rd_q;
      wr_q       <= redirect_i ? '0 : push ? wr_q + PW'(1) : wr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]   <= req_pc_q;
      insn_mem[wr_q] <= imem_data_i;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a pop scoreboard plus direct checks of fetch_queue outputs
module tb_fetch_queue;
  localparam logic [31:0] BASE = 32'h01000000;

  logic        clk = 1'b0, rst, redirect_i, deq_ready_i, ecall_en;
  logic        imem_req_o, deq_valid_o, halted_o;
  logic [31:0] imem_addr_o, imem_data_i, redirect_pc_i, deq_pc_o, deq_insn_o;
  logic [2:0]  count_o;
  logic [63:0] exp_q[$];
  int          checks = 0, passes = 0;

  fetch_queue dut (
    .clk(clk), .rst(rst), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i), .deq_pc_o(deq_pc_o),
    .deq_insn_o(deq_insn_o), .count_o(count_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic en);
    return (en && a == 32'h0100000C) ? 32'h00000073 : {a[13:2], 20'h00013};
  endfunction

  always @(posedge clk) imem_data_i <= mem_word(imem_addr_o, ecall_en);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s got=%h expected=%h", n, act, req);
  endtask

  task automatic push_seg(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({start + 32'(4*i), mem_word(start + 32'(4*i), ecall_en)});
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (rst && deq_valid_o && deq_ready_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL pop_unexpected got pc=%h insn=%h expected no pop", deq_pc_o, deq_insn_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", deq_pc_o, e[63:32]);
        chk("pop_insn", deq_insn_o, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b0; deq_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; ecall_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(deq_valid_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_req", 32'(imem_req_o), 0);
    chk("rst_halted", 32'(halted_o), 0);
    chk("rst_deq_pc", deq_pc_o, 0);
    // reset release and streaming
    tick(1); rst = 1'b1; deq_ready_i = 1'b1; push_seg(BASE, 40);
    @(negedge clk); chk("c0_req", 32'(imem_req_o), 1); chk("c0_addr", imem_addr_o, BASE);
    @(negedge clk); chk("c1_valid", 32'(deq_valid_o), 0);
    @(negedge clk); chk("c2_valid", 32'(deq_valid_o), 1); chk("c2_pc", deq_pc_o, BASE);
    // backpressure fills the FIFO
    tick(6); deq_ready_i = 1'b0;
    tick(9);
    @(negedge clk);
    chk("full_count", 32'(count_o), 4);
    chk("full_req", 32'(imem_req_o), 0);
    chk("full_head", deq_pc_o, BASE + 32'h18);
    tick(1); deq_ready_i = 1'b1;
    // redirect with three entries held
    tick(1); deq_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h01000040;
    exp_q.delete(); push_seg(32'h01000040, 40);
    @(negedge clk); chk("redir_count3", 32'(count_o), 3); chk("redir_req", 32'(imem_req_o), 0);
    tick(1); redirect_i = 1'b0; deq_ready_i = 1'b1;
    @(negedge clk);
    chk("redir_count0", 32'(count_o), 0);
    chk("redir_valid0", 32'(deq_valid_o), 0);
    chk("redir_addr", imem_addr_o, 32'h01000040);
    @(negedge clk); chk("redir_t2_valid", 32'(deq_valid_o), 0);
    @(negedge clk); chk("redir_t3_pc", deq_pc_o, 32'h01000040);
    // misaligned redirect target
    tick(2); redirect_i = 1'b1; redirect_pc_i = 32'h01000042;
    exp_q.delete(); push_seg(32'h01000040, 40);
    tick(1); redirect_i = 1'b0;
    @(negedge clk); chk("align_addr", imem_addr_o, 32'h01000040); chk("align_req", 32'(imem_req_o), 1);
    @(negedge clk); @(negedge clk); chk("align_pc", deq_pc_o, 32'h01000040);
    // ECALL halts fetch
    tick(1); ecall_en = 1'b1; redirect_i = 1'b1; redirect_pc_i = BASE;
    exp_q.delete(); push_seg(BASE, 6);
    tick(1); redirect_i = 1'b0;
    @(negedge clk); chk("pre_halt", 32'(halted_o), 0);
    tick(6);
    @(negedge clk); chk("halted", 32'(halted_o), 1); chk("halt_req", 32'(imem_req_o), 0);
    tick(2);
    @(negedge clk);
    chk("halt_drain_count", 32'(count_o), 0);
    chk("halt_drain_req", 32'(imem_req_o), 0);
    chk("halt_exp_left", 32'(exp_q.size()), 0);
    tick(2); redirect_i = 1'b1; redirect_pc_i = 32'h01000100; exp_q.delete(); push_seg(32'h01000100, 40);
    @(negedge clk); chk("halt_hold", 32'(halted_o), 1);
    tick(1); redirect_i = 1'b0;
    @(negedge clk); chk("resume_halted", 32'(halted_o), 0); chk("resume_addr", imem_addr_o, 32'h01000100);
    chk("resume_req", 32'(imem_req_o), 1);
    @(negedge clk); @(negedge clk); chk("resume_pc", deq_pc_o, 32'h01000100);
    // asynchronous reset with a full FIFO
    tick(2); deq_ready_i = 1'b0;
    tick(8);
    @(negedge clk); chk("pre_rst_count", 32'(count_o), 4);
    #2; exp_q.delete(); rst = 1'b0;
    #1;
    chk("arst_valid", 32'(deq_valid_o), 0);
    chk("arst_count", 32'(count_o), 0);
    chk("arst_req", 32'(imem_req_o), 0);
    chk("arst_pc", deq_pc_o, 0);
    chk("arst_addr", imem_addr_o, BASE);
    tick(1); rst = 1'b1; ecall_en = 1'b0; deq_ready_i = 1'b1; push_seg(BASE, 40);
    @(negedge clk); chk("rs_addr", imem_addr_o, BASE);
    @(negedge clk); @(negedge clk); chk("rs_pc", deq_pc_o, BASE);
    tick(3); deq_ready_i = 1'b0;
    tick(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
